// File: rtl/four_bit_register_sequencer_pkg.sv
// Shared types and constants for the SAP-style control sequencer.
package four_bit_register_sequencer_pkg;

    localparam int unsigned DEF_DW  = 4;
    localparam int unsigned DEF_OPW = 4;
    localparam int unsigned STEPS   = 6;
    localparam int unsigned TW      = 3;

    typedef enum logic [TW-1:0] {
        T_IDLE = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        T4     = 3'd4,
        T5     = 3'd5,
        T6     = 3'd6,
        T_HALT = 3'd7
    } t_state_e;

    localparam logic [DEF_OPW-1:0] OP_NOP = 4'h0;
    localparam logic [DEF_OPW-1:0] OP_LDA = 4'h1;
    localparam logic [DEF_OPW-1:0] OP_LDB = 4'h2;
    localparam logic [DEF_OPW-1:0] OP_ADD = 4'h3;
    localparam logic [DEF_OPW-1:0] OP_SUB = 4'h4;
    localparam logic [DEF_OPW-1:0] OP_OUT = 4'hE;
    localparam logic [DEF_OPW-1:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic pc_en;
        logic pc_inc;
        logic mar_load;
        logic mem_en;
        logic ir_load;
        logic ir_en;
        logic latch_a;
        logic latch_b;
        logic alu_en;
        logic sub;
        logic out_load;
        logic halted;
        logic illegal;
    } strobes_t;

endpackage

// File: rtl/four_bit_register_sequencer_ring_counter.sv
// IDLE / T1..T6 / HALT step counter; HALT is left only through reset.
module four_bit_register_sequencer_ring_counter
    import four_bit_register_sequencer_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     run,
    input  logic     halt_req,
    output t_state_e state_q,
    output t_state_e next_state_c
);

    t_state_e state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            T_IDLE:  state_d = run ? T1 : T_IDLE;
            T1:      state_d = T2;
            T2:      state_d = T3;
            T3:      state_d = halt_req ? T_HALT : T4;
            T4:      state_d = T5;
            T5:      state_d = T6;
            T6:      state_d = run ? T1 : T_IDLE;
            T_HALT:  state_d = T_HALT;
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= T_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign next_state_c = state_d;

endmodule

// File: rtl/four_bit_register_sequencer.sv
// Control sequencer top: latches the instruction at T3->T4 and registers
// the strobe decode of the upcoming step so strobes align with t_state.
module four_bit_register_sequencer
    import four_bit_register_sequencer_pkg::*;
#(
    parameter int unsigned DW  = DEF_DW,
    parameter int unsigned OPW = DEF_OPW
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic [DW-1:0]  operand,
    output logic           pc_en,
    output logic           pc_inc,
    output logic           mar_load,
    output logic           mem_en,
    output logic           ir_load,
    output logic           ir_en,
    output logic           latch_a,
    output logic           latch_b,
    output logic [DW-1:0]  b_data,
    output logic           alu_en,
    output logic           sub,
    output logic           out_load,
    output logic [TW-1:0]  t_state,
    output logic           halted,
    output logic           illegal
);

    t_state_e       state_q;
    t_state_e       state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  arg_q, arg_d;
    logic [DW-1:0]  b_data_q, b_data_d;
    strobes_t       strb_q, strb_d;
    logic           halt_req;

    assign halt_req = (opcode == OPW'(OP_HLT));

    four_bit_register_sequencer_ring_counter u_ring (
        .clk          (clk),
        .reset_n      (reset_n),
        .run          (run),
        .halt_req     (halt_req),
        .state_q      (state_q),
        .next_state_c (state_d)
    );

    // Instruction fields are captured only on the T3->T4 edge.
    always_comb begin
        op_d  = op_q;
        arg_d = arg_q;
        if (state_q == T3) begin
            op_d  = opcode;
            arg_d = operand;
        end
    end

    always_comb begin
        strb_d   = '0;
        b_data_d = b_data_q;
        case (state_d)
            T1: begin
                strb_d.pc_en    = 1'b1;
                strb_d.mar_load = 1'b1;
            end
            T2: strb_d.pc_inc = 1'b1;
            T3: begin
                strb_d.mem_en  = 1'b1;
                strb_d.ir_load = 1'b1;
            end
            T4: begin
                if (op_d == OPW'(OP_LDA) || op_d == OPW'(OP_ADD) || op_d == OPW'(OP_SUB)) begin
                    strb_d.ir_en    = 1'b1;
                    strb_d.mar_load = 1'b1;
                end else if (op_d == OPW'(OP_LDB)) begin
                    strb_d.latch_b = 1'b1;
                    b_data_d       = arg_d;
                end else if (op_d == OPW'(OP_OUT)) begin
                    strb_d.out_load = 1'b1;
                end else if (op_d != OPW'(OP_NOP)) begin
                    strb_d.illegal = 1'b1;
                end
            end
            T5: begin
                if (op_d == OPW'(OP_LDA)) begin
                    strb_d.mem_en  = 1'b1;
                    strb_d.latch_a = 1'b1;
                end else if (op_d == OPW'(OP_ADD) || op_d == OPW'(OP_SUB)) begin
                    strb_d.mem_en  = 1'b1;
                    strb_d.latch_b = 1'b1;
                end
            end
            T6: begin
                if (op_d == OPW'(OP_ADD) || op_d == OPW'(OP_SUB)) begin
                    strb_d.alu_en  = 1'b1;
                    strb_d.latch_a = 1'b1;
                    strb_d.sub     = (op_d == OPW'(OP_SUB));
                end
            end
            T_HALT:  strb_d.halted = 1'b1;
            default: strb_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q     <= '0;
            arg_q    <= '0;
            b_data_q <= '0;
            strb_q   <= '0;
        end else begin
            op_q     <= op_d;
            arg_q    <= arg_d;
            b_data_q <= b_data_d;
            strb_q   <= strb_d;
        end
    end

    assign pc_en    = strb_q.pc_en;
    assign pc_inc   = strb_q.pc_inc;
    assign mar_load = strb_q.mar_load;
    assign mem_en   = strb_q.mem_en;
    assign ir_load  = strb_q.ir_load;
    assign ir_en    = strb_q.ir_en;
    assign latch_a  = strb_q.latch_a;
    assign latch_b  = strb_q.latch_b;
    assign alu_en   = strb_q.alu_en;
    assign sub      = strb_q.sub;
    assign out_load = strb_q.out_load;
    assign halted   = strb_q.halted;
    assign illegal  = strb_q.illegal;
    assign b_data   = b_data_q;
    assign t_state  = TW'(state_q);

endmodule

// File: tb/tb_four_bit_register_sequencer.sv
// Scoreboard bench: a step-level instruction model predicts every cycle's outputs.
module tb_four_bit_register_sequencer;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en;
    logic       latch_a, latch_b, alu_en, sub, out_load, halted, illegal;
    logic [3:0] b_data;
    logic [2:0] t_state;

    four_bit_register_sequencer dut (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .operand(operand),
        .pc_en(pc_en), .pc_inc(pc_inc), .mar_load(mar_load), .mem_en(mem_en),
        .ir_load(ir_load), .ir_en(ir_en), .latch_a(latch_a), .latch_b(latch_b),
        .b_data(b_data), .alu_en(alu_en), .sub(sub), .out_load(out_load),
        .t_state(t_state), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;
    bit [19:0]   exp_q[$];

    // Reference model: step number (0 idle, 1..6, 7 halted), current instruction, B contents.
    int         m_step = 0;
    logic [3:0] m_op   = 4'h0;
    logic [3:0] m_arg  = 4'h0;
    logic [3:0] m_b    = 4'h0;
    int         halt_cycles = 0;

    function automatic bit [19:0] expect_vec(input int step, input logic [3:0] op, input logic [3:0] b);
        bit pe, pi, ml, me, irl, ie, la, lb, ae, sb, ol, h, ill;
        bit is_arith;
        {pe, pi, ml, me, irl, ie, la, lb, ae, sb, ol, h, ill} = '0;
        is_arith = (op == 4'h3) || (op == 4'h4);
        case (step)
            1: begin pe = 1; ml = 1; end
            2: pi = 1;
            3: begin me = 1; irl = 1; end
            4: begin
                if (op == 4'h1 || is_arith) begin ie = 1; ml = 1; end
                else if (op == 4'h2) lb = 1;
                else if (op == 4'hE) ol = 1;
                else if (op != 4'h0) ill = 1;
            end
            5: begin
                if (op == 4'h1) begin me = 1; la = 1; end
                else if (is_arith) begin me = 1; lb = 1; end
            end
            6: if (is_arith) begin ae = 1; la = 1; sb = (op == 4'h4); end
            7: h = 1;
            default: ;
        endcase
        return {pe, pi, ml, me, irl, ie, la, lb, ae, sb, ol, h, ill, 3'(step), b};
    endfunction

    task automatic drive(input logic rn, input logic r, input logic [3:0] op, input logic [3:0] arg);
        @(negedge clk);
        reset_n = rn;
        run     = r;
        opcode  = op;
        operand = arg;
        if (!rn) begin
            m_step = 0;
            m_op   = 4'h0;
            m_arg  = 4'h0;
            m_b    = 4'h0;
        end else begin
            case (m_step)
                0, 6: m_step = r ? 1 : 0;
                3: begin
                    m_op   = op;
                    m_arg  = arg;
                    m_step = (op == 4'hF) ? 7 : 4;
                end
                7: m_step = 7;
                default: m_step = m_step + 1;
            endcase
            if (m_step == 4 && m_op == 4'h2) m_b = m_arg;
        end
        exp_q.push_back(expect_vec(m_step, m_op, m_b));
    endtask

    task automatic instr(input logic [3:0] op, input logic [3:0] arg, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, op, arg);
    endtask

    // Monitor: compares DUT outputs with the oldest prediction one step after each edge.
    initial begin
        bit [19:0] got, want;
        int        drivers;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                cyc++;
                want = exp_q.pop_front();
                got  = {pc_en, pc_inc, mar_load, mem_en, ir_load, ir_en, latch_a, latch_b,
                        alu_en, sub, out_load, halted, illegal, t_state, b_data};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %b expected %b (strobes|h|ill|t|b)",
                             cyc, got, want);
                end
                checks++;
                if ((latch_a & latch_b) !== 1'b0) begin
                    errors++;
                    $display("FAIL latch_excl cycle %0d: latch_a=%b latch_b=%b required not both 1",
                             cyc, latch_a, latch_b);
                end
                drivers = int'(alu_en) + int'(mem_en) + int'(pc_en) + int'(ir_en);
                checks++;
                if (drivers > 1) begin
                    errors++;
                    $display("FAIL bus_excl cycle %0d: %0d bus drivers, required at most 1",
                             cyc, drivers);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        opcode  = 4'h0;
        operand = 4'h0;
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        drive(1'b0, 1'b1, 4'h0, 4'h0);
        // LDB 5, LDB 7, LDB D back to back
        instr(4'h2, 4'h5, 6);
        instr(4'h2, 4'h7, 6);
        instr(4'h2, 4'hD, 6);
        instr(4'h3, 4'h9, 6);
        instr(4'h4, 4'h9, 6);
        instr(4'h0, 4'h3, 6);
        instr(4'hE, 4'h1, 6);
        // LDA aborted by reset before T5
        instr(4'h1, 4'h6, 4);
        drive(1'b0, 1'b1, 4'h1, 4'h6);
        drive(1'b1, 1'b0, 4'h1, 4'h6);
        // illegal opcode, run dropped during T5
        instr(4'hA, 4'h2, 5);
        drive(1'b1, 1'b0, 4'hA, 4'h2);
        drive(1'b1, 1'b0, 4'hA, 4'h2);
        drive(1'b1, 1'b0, 4'hA, 4'h2);
        instr(4'h2, 4'hB, 6);
        // HLT holds for 20+ cycles with run high, then reset
        instr(4'hF, 4'h0, 3);
        instr(4'hF, 4'h0, 23);
        drive(1'b0, 1'b1, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 4'h0, 4'h0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic       rn, r;
            logic [3:0] op, arg;
            rn  = ($urandom_range(0, 63) != 0);
            r   = ($urandom_range(0, 7) != 0);
            op  = 4'($urandom_range(0, 15));
            arg = 4'($urandom_range(0, 15));
            halt_cycles = (m_step == 7) ? halt_cycles + 1 : 0;
            if (halt_cycles > 8) rn = 1'b0;
            drive(rn, r, op, arg);
        end
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
